fp32_mul_booth4: RTL and testbench

Sequential IEEE-754 single-precision multiplier, the companion to the SRT radix-4 FP32 divider in the same arithmetic unit. It recodes the multiplier mantissa into radix-4 Booth digits in {-2..2}, the same digit set and 3-bit sign-magnitude digit encoding the divider uses for its quotient digits. It accumulates one partial product per cycle, then normalizes and rounds to nearest-even. It has a start/done handshake and a fixed latency, so divider and multiplier share one issue/retire scheme.

---
 rtl/fp32_pkg.sv | 36 +++
 rtl/booth4_pp_gen.sv | 24 ++
 rtl/fp32_mul_booth4.sv | 157 +++++++++++++++
 tb/tb_fp32_mul_booth4.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 arithmetic-unit definitions: format constants, sequencer states and
// the radix-4 sign-magnitude digit used by both the Booth multiplier and the SRT divider.
package fp32_pkg;

  localparam int          FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_INF_EXP = 8'hFF;

  localparam int          MANT_W     = 24;  // mantissa with hidden bit
  localparam int          ACC_W      = 50;  // signed partial-product accumulator
  localparam int          PP_SHIFT   = 22;  // alignment of each partial product in the accumulator
  localparam logic [3:0]  LAST_DIGIT = 4'd12;

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;

  // Digit in {-2..2} as sign + magnitude; zero is always encoded with neg=0.
  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } sm_digit_t;

  // Radix-4 Booth recoding of the window {y[2i+1], y[2i], y[2i-1]}.
  function automatic sm_digit_t booth_recode(input logic [2:0] window);
    sm_digit_t d;
    d = '0;
    case (window)
      3'b001, 3'b010: d = '{neg: 1'b0, mag: 2'd1};
      3'b011:         d = '{neg: 1'b0, mag: 2'd2};
      3'b100:         d = '{neg: 1'b1, mag: 2'd2};
      3'b101, 3'b110: d = '{neg: 1'b1, mag: 2'd1};
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth4_pp_gen.sv
// Radix-4 Booth partial-product generator: recodes one multiplier window and forms
// |digit| x m_a; the sign travels separately in digit.neg for the accumulator to apply.
module booth4_pp_gen
  import fp32_pkg::*;
(
  input  logic [2:0]        window,
  input  logic [MANT_W-1:0] m_a,
  output sm_digit_t         digit,
  output logic [MANT_W+1:0] pp
);

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    digit = booth_recode(window);
    pp    = '0;
    case (digit.mag)
      2'd1:    pp = {2'b00, m_a};
      2'd2:    pp = {1'b0, m_a, 1'b0};
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/fp32_mul_booth4.sv
// Sequential FP32 multiplier: one radix-4 Booth digit per cycle, then normalize and
// round-to-nearest-even; fixed 15-cycle start-to-done latency, specials included.
module fp32_mul_booth4
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  state_t                   state, state_nxt;
  logic [3:0]               cnt;
  logic [MANT_W-1:0]        m_a;
  logic [MANT_W+1:0]        mb_sr;
  logic signed [ACC_W-1:0]  acc;
  logic                     sticky, sign_r, special_r;
  logic signed [9:0]        exp_r;
  logic [31:0]              special_val_r;

  logic        accept, sign_in, special_in;
  logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [31:0] special_val;

  assign accept  = (state == IDLE) && start;
  assign sign_in = a[31] ^ b[31];
  assign a_zero  = (a[30:23] == 8'h00);
  assign b_zero  = (b[30:23] == 8'h00);
  assign a_nan   = (a[30:23] == FP32_INF_EXP) && (a[22:0] != '0);
  assign b_nan   = (b[30:23] == FP32_INF_EXP) && (b[22:0] != '0);
  assign a_inf   = (a[30:23] == FP32_INF_EXP) && (a[22:0] == '0);
  assign b_inf   = (b[30:23] == FP32_INF_EXP) && (b[22:0] == '0);

  // Denormal operands have a zero exponent field and are treated as zero.
  always_comb begin
    special_in  = 1'b1;
    special_val = FP32_QNAN;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      special_val = FP32_QNAN;
    else if (a_inf || b_inf)
      special_val = {sign_in, FP32_INF_EXP, 23'h0};
    else if (a_zero || b_zero)
      special_val = {sign_in, 31'h0};
    else
      special_in = 1'b0;
  end

  // NOTE: state is written with non-blocking assignments and cleared by the
  // asynchronous reset, so every flop samples its pre-edge inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ITER;
      ITER:    if (cnt == LAST_DIGIT) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ITER) || (state == NORM);
    done = (state == DONE);
  end

  // Booth step: add the signed partial product at the top, then shift right by 2;
  // the bits leaving the bottom are final product bits and only feed sticky.
  sm_digit_t         digit;
  logic [MANT_W+1:0] pp;
  logic [ACC_W-1:0]  pp_mag, addend;
  logic signed [ACC_W-1:0] acc_sum;

  booth4_pp_gen u_pp_gen (
    .window (mb_sr[2:0]),
    .m_a    (m_a),
    .digit  (digit),
    .pp     (pp)
  );

  assign pp_mag = {2'b00, pp, {PP_SHIFT{1'b0}}};

  always_comb begin
    addend = '0;
    if (digit.mag != 2'd0)
      addend = digit.neg ? (~pp_mag + ACC_W'(1)) : pp_mag;
  end

  assign acc_sum = acc + $signed(addend);

  // acc[43] holds product bit 47; the bits above it are always zero for a real product.
  logic                norm_hi, guard, rnd, stk, round_up;
  logic [43:0]         nv;
  logic [MANT_W-1:0]   mant;
  logic [MANT_W:0]     mant_rnd;
  logic [22:0]         frac;
  logic signed [9:0]   exp_n;
  logic [31:0]         result;

  always_comb begin
    norm_hi  = |acc[ACC_W-1:43];
    nv       = norm_hi ? acc[43:0] : {acc[42:0], 1'b0};
    mant     = nv[43:20];
    guard    = nv[19];
    rnd      = nv[18];
    stk      = (|nv[17:0]) | sticky;
    round_up = guard & (rnd | stk | mant[0]);
    mant_rnd = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
    exp_n    = exp_r + 10'(norm_hi) + 10'(mant_rnd[MANT_W]);
    frac     = mant_rnd[MANT_W] ? mant_rnd[23:1] : mant_rnd[22:0];
    if (special_r)              result = special_val_r;
    else if (exp_n >= 10'sd255) result = {sign_r, FP32_INF_EXP, 23'h0};
    else if (exp_n <= 10'sd0)   result = {sign_r, 31'h0};
    else                        result = {sign_r, exp_n[7:0], frac};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      m_a           <= '0;
      mb_sr         <= '0;
      acc           <= '0;
      sticky        <= 1'b0;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      special_r     <= 1'b0;
      special_val_r <= '0;
      product       <= '0;
    end else if (accept) begin
      cnt           <= '0;
      m_a           <= {~a_zero, a[22:0]};
      mb_sr         <= {1'b0, ~b_zero, b[22:0], 1'b0};
      acc           <= '0;
      sticky        <= 1'b0;
      sign_r        <= sign_in;
      exp_r         <= 10'(a[30:23]) + 10'(b[30:23]) - 10'(FP32_BIAS);
      special_r     <= special_in;
      special_val_r <= special_val;
    end else if (state == ITER) begin
      acc    <= acc_sum >>> 2;
      sticky <= sticky | (|acc_sum[1:0]);
      mb_sr  <= mb_sr >> 2;
      cnt    <= cnt + 4'd1;
    end else if (state == NORM) begin
      product <= result;
    end
  end

endmodule

// File: tb/tb_fp32_mul_booth4.sv
// Scoreboard bench for fp32_mul_booth4: directed cases plus randomized operands checked
// against an integer-arithmetic IEEE-754 reference, with latency and busy tracking.
module tb_fp32_mul_booth4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] product;

  always #5 clk = ~clk;

  fp32_mul_booth4 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  int          busy_lo = 1;
  int          busy_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact 48-bit product with plain integer math, then RNE by remainder.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ex, ey, e, sh;
    logic        xnan, ynan, xinf, yinf, xz, yz;
    logic [63:0] mx, my, p, q, rem, half;
    s    = x[31] ^ y[31];
    ex   = int'(x[30:23]);
    ey   = int'(y[30:23]);
    xnan = (ex == 255) && (x[22:0] != 0);
    ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0);
    yinf = (ey == 255) && (y[22:0] == 0);
    xz   = (ex == 0);
    yz   = (ey == 0);
    if (xnan || ynan || (xinf && yz) || (yinf && xz)) return 32'h7FC0_0000;
    if (xinf || yinf) return {s, 8'hFF, 23'h0};
    if (xz || yz)     return {s, 31'h0};
    mx = {40'h0, 1'b1, x[22:0]};
    my = {40'h0, 1'b1, y[22:0]};
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= 64'h8000_0000_0000) begin sh = 24; e++; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'h1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == 64'h100_0000) begin q = q >> 1; e++; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 11);
    case (sel)
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = '0; end
      2: v[22:0]  = '0;
      3: v[30:23] = 8'($urandom_range(200, 254));
      4: v[30:23] = 8'($urandom_range(1, 60));
      5: v[22:0]  = 23'($urandom_range(0, 3));
      default: v[30:23] = 8'($urandom_range(64, 190));
    endcase
    return v;
  endfunction

  // Monitor: busy against the expected window, and every done against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      check("busy", {31'b0, busy}, {31'b0, (edges >= busy_lo) && (edges <= busy_hi)});
      if (done) begin
        if (exp_q.size() == 0) check("spurious_done", {31'b0, done}, 32'h0);
        else begin
          check("product", product, exp_q.pop_front());
          check("latency", 32'(edges), 32'(cyc_q.pop_front()));
        end
      end
    end
  end

  // Driver is always positioned 1 time unit after a falling edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(expv);
    cyc_q.push_back(edges + 15);
    busy_lo = edges + 1;
    busy_hi = edges + 14;
    @(negedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Returns in the cycle after done; optionally pokes start during the done cycle.
  task automatic wait_done(input bit poke);
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    check("timeout", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    cyc_q.delete();
    if (poke) begin
      start = 1'b1;
      a     = rand_fp();
      b     = rand_fp();
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  logic [31:0] dir_tab [7][3] = '{
    '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000},
    '{32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002},
    '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002},
    '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000},
    '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000},
    '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000},
    '{32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000}
  };

  initial begin
    logic [31:0] x, y;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_product", product, 32'h0);
    rst = 1'b1;
    @(negedge clk); #1;

    // 3.0 x 2.0 with a second start at cycle 5 that must be ignored.
    issue(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
    repeat (4) begin @(negedge clk); #1; end
    start = 1'b1;
    a     = 32'h7F7F_FFFF;
    b     = 32'h4000_0000;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(1'b1);

    for (int i = 0; i < 7; i++) begin
      issue(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2]);
      wait_done(i[0]);
    end

    // Abort mid-operation: reset low in cycle 7, released in cycle 8, restart in cycle 10.
    issue(32'h4040_0000, 32'h4040_0000, 32'h4110_0000);
    repeat (6) begin @(negedge clk); #1; end
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_product", product, 32'h0);
    exp_q.delete();
    cyc_q.delete();
    busy_hi = busy_lo - 1;
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    issue(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    wait_done(1'b0);

    repeat (40) begin
      x = rand_fp();
      y = rand_fp();
      issue(x, y, ref_mul(x, y));
      wait_done(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
